// File: rtl/udm_bus_arb_pkg.sv
// Shared definitions for the UDM two-master bus arbiter: default widths,
// master ID encoding and a small helper.
package udm_bus_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_id_t;

  // The master that is not m; used to hand round-robin priority over.
  function automatic mst_id_t other_mst(input mst_id_t m);
    return (m == MST_M0) ? MST_M1 : MST_M0;
  endfunction

endpackage

// File: rtl/udm_bus_arb_idfifo.sv
// 1-bit-wide master-ID FIFO. It remembers which master issued each outstanding
// read, so that read responses can be routed back in slave order.
module udm_bus_arb_idfifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage array; contents are meaningless while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy. DEPTH is a power of 2, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udm_bus_arb.sv
// Two-master, one-slave arbiter for the UDM req/ack/resp bus. Round-robin on
// the request phase; read responses are steered back through a master-ID FIFO
// so the slave may keep several reads in flight.
module udm_bus_arb
  import udm_bus_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        m0_req_i,
  input  logic                        m0_we_i,
  input  logic [ADDR_W-1:0]           m0_addr_bi,
  input  logic [DATA_W/8-1:0]         m0_be_bi,
  input  logic [DATA_W-1:0]           m0_wdata_bi,
  output logic                        m0_ack_o,
  output logic                        m0_resp_o,
  output logic [DATA_W-1:0]           m0_rdata_bo,
  input  logic                        m1_req_i,
  input  logic                        m1_we_i,
  input  logic [ADDR_W-1:0]           m1_addr_bi,
  input  logic [DATA_W/8-1:0]         m1_be_bi,
  input  logic [DATA_W-1:0]           m1_wdata_bi,
  output logic                        m1_ack_o,
  output logic                        m1_resp_o,
  output logic [DATA_W-1:0]           m1_rdata_bo,
  output logic                        s_req_o,
  output logic                        s_we_o,
  output logic [ADDR_W-1:0]           s_addr_bo,
  output logic [DATA_W/8-1:0]         s_be_bo,
  output logic [DATA_W-1:0]           s_wdata_bo,
  input  logic                        s_ack_i,
  input  logic                        s_resp_i,
  input  logic [DATA_W-1:0]           s_rdata_bi,
  output logic [$clog2(RD_DEPTH):0]   rd_pend_bo,
  output logic                        err_o
);

  localparam int CNT_W = $clog2(RD_DEPTH) + 1;

  mst_id_t rr_ptr;
  mst_id_t lock_id;
  logic    lock_vld;
  mst_id_t gnt;
  mst_id_t head;
  logic    gnt_req;
  logic    gnt_we;
  logic    hs;
  logic    push;
  logic    pop;
  logic    fifo_dout;
  logic    fifo_full;
  logic    fifo_empty;

  // Grant selection: a request already presented to the slave keeps its grant
  // until acked; otherwise a lone requester wins and a tie goes to rr_ptr.
  always_comb begin
    gnt = MST_M0;
    if (lock_vld && ((lock_id == MST_M1) ? m1_req_i : m0_req_i)) gnt = lock_id;
    else if (m0_req_i && m1_req_i)                                 gnt = rr_ptr;
    else if (m1_req_i)                                             gnt = MST_M1;
  end

  assign gnt_req = (gnt == MST_M1) ? m1_req_i : m0_req_i;
  assign gnt_we  = (gnt == MST_M1) ? m1_we_i  : m0_we_i;

  // Slave-side request and field mux. Reads stall on a full ID FIFO; a
  // same-cycle response is deliberately not used to release the stall.
  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    if (!rst_i) begin
      s_req_o    = gnt_req && !(!gnt_we && fifo_full);
      s_we_o     = gnt_we;
      s_addr_bo  = (gnt == MST_M1) ? m1_addr_bi  : m0_addr_bi;
      s_be_bo    = (gnt == MST_M1) ? m1_be_bi    : m0_be_bi;
      s_wdata_bo = (gnt == MST_M1) ? m1_wdata_bi : m0_wdata_bi;
    end
  end

  assign hs       = s_req_o & s_ack_i;
  assign m0_ack_o = hs & (gnt == MST_M0);
  assign m1_ack_o = hs & (gnt == MST_M1);
  assign push     = hs & ~s_we_o;
  assign pop      = ~rst_i & s_resp_i & ~fifo_empty;
  assign head     = mst_id_t'(fifo_dout);

  assign m0_resp_o   = pop & (head == MST_M0);
  assign m1_resp_o   = pop & (head == MST_M1);
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

  udm_bus_arb_idfifo #(
    .DEPTH (RD_DEPTH),
    .CNT_W (CNT_W)
  ) u_idfifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .din   (gnt),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rd_pend_bo)
  );

  // Round-robin pointer, grant lock for un-acked presented requests, and the
  // sticky orphan-response error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= MST_M0;
      lock_vld <= 1'b0;
      lock_id  <= MST_M0;
      err_o    <= 1'b0;
    end else begin
      if (hs) rr_ptr <= other_mst(gnt);
      lock_vld <= s_req_o & ~s_ack_i;
      lock_id  <= gnt;
      if (s_resp_i && fifo_empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udm_bus_arb.sv
// Directed bench for udm_bus_arb with RD_DEPTH=4.
module tb_udm_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ack, s_resp;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic [2:0]  rd_pend;
  logic        err;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  udm_bus_arb #(.ADDR_W(32), .DATA_W(32), .RD_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(m0_be),
    .m0_wdata_bi(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(m1_be),
    .m1_wdata_bi(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be), .s_wdata_bo(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
    .rd_pend_bo(rd_pend), .err_o(err)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_be = 4'hF; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 4'hF; m1_wdata = 0;
    s_ack = 0; s_resp = 0; s_rdata = 0;
    settle();
    check_val("rst_pend", rd_pend, 0);
    check_val("rst_err", err, 0);
    check_val("rst_sreq", s_req, 0);
    tick();
    rst = 1'b0;

    // 1: single M0 write
    m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'hA5A5; s_ack = 1;
    settle();
    check_val("t1_sreq", s_req, 1);
    check_val("t1_swe", s_we, 1);
    check_val("t1_saddr", s_addr, 32'h0);
    check_val("t1_swdata", s_wdata, 32'hA5A5);
    check_val("t1_sbe", s_be, 4'hF);
    check_val("t1_m0ack", m0_ack, 1);
    check_val("t1_m1ack", m1_ack, 0);
    tick();
    m0_req = 0;
    settle();
    check_val("t1_pend", rd_pend, 0);

    // 2: both read; rr_ptr now points at M1 after M0's write
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    settle();
    check_val("t2a_saddr", s_addr, 32'h20);
    check_val("t2a_m1ack", m1_ack, 1);
    check_val("t2a_m0ack", m0_ack, 0);
    tick();
    s_resp = 1; s_rdata = 32'h20;
    settle();
    check_val("t2b_saddr", s_addr, 32'h10);
    check_val("t2b_m0ack", m0_ack, 1);
    check_val("t2b_m1resp", m1_resp, 1);
    check_val("t2b_m1rdata", m1_rdata, 32'h20);
    check_val("t2b_m0resp", m0_resp, 0);
    check_val("t2b_m0rdata", m0_rdata, 0);
    tick();
    s_rdata = 32'h10;
    settle();
    check_val("t2c_saddr", s_addr, 32'h20);
    check_val("t2c_m1ack", m1_ack, 1);
    check_val("t2c_m0resp", m0_resp, 1);
    check_val("t2c_m0rdata", m0_rdata, 32'h10);
    check_val("t2c_pend", rd_pend, 1);
    tick();
    m0_req = 0; m1_req = 0; s_rdata = 32'h20;
    settle();
    check_val("t2d_m1resp", m1_resp, 1);
    check_val("t2d_m1rdata", m1_rdata, 32'h20);
    tick();
    s_resp = 0;
    settle();
    check_val("t2_pend", rd_pend, 0);

    // 3: fill FIFO with M1,M1,M1,M0 reads (rr_ptr ends at M1)
    m1_req = 1; m1_addr = 32'h30;
    tick(); tick(); tick();
    m1_req = 0;
    m0_req = 1; m0_addr = 32'h40;
    settle();
    check_val("t3_m0ack4", m0_ack, 1);
    tick();
    settle();
    check_val("t3_pend4", rd_pend, 4);
    m0_addr = 32'h44;
    check_val("t3_stall_sreq", s_req, 0);
    check_val("t3_stall_m0ack", m0_ack, 0);
    tick();
    m1_req = 1; m1_we = 1; m1_addr = 32'h50; m1_wdata = 32'h1234;
    settle();
    check_val("t3_wr_sreq", s_req, 1);
    check_val("t3_wr_swe", s_we, 1);
    check_val("t3_wr_saddr", s_addr, 32'h50);
    check_val("t3_wr_m1ack", m1_ack, 1);
    check_val("t3_wr_m0ack", m0_ack, 0);
    tick();
    m1_req = 0; m1_we = 0;
    settle();
    check_val("t3_pend_after_wr", rd_pend, 4);

    // 4: response while full; stalled M0 read goes next cycle
    s_resp = 1; s_rdata = 32'hBEEF;
    settle();
    check_val("t4_m1resp", m1_resp, 1);
    check_val("t4_m1rdata", m1_rdata, 32'hBEEF);
    check_val("t4_m0resp", m0_resp, 0);
    check_val("t4_sreq", s_req, 0);
    tick();
    s_resp = 0;
    settle();
    check_val("t4_pend3", rd_pend, 3);
    check_val("t4_sreq_go", s_req, 1);
    check_val("t4_m0ack", m0_ack, 1);
    tick();
    m0_req = 0;
    settle();
    check_val("t4_pend4", rd_pend, 4);
    // drain: FIFO order is M1,M1,M0,M0
    s_resp = 1;
    for (int i = 0; i < 4; i++) begin
      s_rdata = 32'h100 + i;
      settle();
      check_val("t4_drain_m1resp", m1_resp, (i < 2) ? 1 : 0);
      check_val("t4_drain_m0resp", m0_resp, (i < 2) ? 0 : 1);
      check_val("t4_drain_rdata", (i < 2) ? m1_rdata : m0_rdata, 32'h100 + i);
      tick();
    end
    s_resp = 0;
    settle();
    check_val("t4_pend0", rd_pend, 0);
    check_val("t4_err0", err, 0);

    // 5: orphan response
    s_resp = 1; s_rdata = 32'hDEAD;
    settle();
    check_val("t5_m0resp", m0_resp, 0);
    check_val("t5_m1resp", m1_resp, 0);
    check_val("t5_m1rdata", m1_rdata, 0);
    tick();
    s_resp = 0;
    settle();
    check_val("t5_err", err, 1);
    tick(); tick();
    check_val("t5_err_sticky", err, 1);

    // 6: asynchronous reset with 2 reads pending
    m0_req = 1; m0_addr = 32'h60;
    tick(); tick();
    m1_req = 1; m1_addr = 32'h70;
    settle();
    check_val("t6_pend2", rd_pend, 2);
    rst = 1'b1;
    #1;
    check_val("t6_rst_pend", rd_pend, 0);
    check_val("t6_rst_err", err, 0);
    check_val("t6_rst_sreq", s_req, 0);
    check_val("t6_rst_m0ack", m0_ack, 0);
    check_val("t6_rst_saddr", s_addr, 0);
    tick();
    rst = 1'b0;
    settle();
    check_val("t6_first_m0ack", m0_ack, 1);
    check_val("t6_first_m1ack", m1_ack, 0);
    check_val("t6_first_saddr", s_addr, 32'h60);
    tick();
    m0_req = 0; m1_req = 0; s_ack = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
